// File: rtl/fan_ctrl_pkg.sv
// Shared definitions for the multi-channel fan controller: the per-channel
// state encoding and a saturating subtract used for the lower thresholds.
package fan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_KICK = 2'd1,
    ST_RUN  = 2'd2,
    ST_FULL = 2'd3
  } fan_state_e;

  // a - b, clamped at zero instead of wrapping
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/fan_ch_fsm.sv
// One fan channel: threshold/hysteresis state machine with kick-start,
// glitch-free duty latch and registered PWM compare.
// With FAN_TACH_EN defined, also a tach stall detector for the channel.
module fan_ch_fsm
  import fan_ctrl_pkg::*;
#(
  parameter int TW         = 12,
  parameter int PWM_BITS   = 8,
  parameter int KICK_TICKS = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                wrap,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [TW-1:0]       temp_q,
  input  logic [TW-1:0]       thr_on,
  input  logic [TW-1:0]       thr_full,
  input  logic [TW-1:0]       hyst,
  input  logic [PWM_BITS-1:0] duty_run,
  input  logic                override,
  output logic                fan_pwm,
`ifdef FAN_TACH_EN
  input  logic                fan_tach,
  output logic                fan_stall,
`endif
  output logic [1:0]          fan_state
);

  localparam int            KW        = $clog2(KICK_TICKS + 1);
  localparam logic [KW-1:0] KICK_LAST = KW'(KICK_TICKS - 1);

  fan_state_e          state_q, state_d;
  logic [KW-1:0]       kick_q, kick_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pwm_q, pwm_d;
  logic [TW-1:0]       off_thr, run_thr;

  assign off_thr = TW'(sat_sub(32'(thr_on), 32'(hyst)));
  assign run_thr = TW'(sat_sub(32'(thr_full), 32'(hyst)));

  // Next state and kick counter; the override wins over every state
  always_comb begin
    state_d = state_q;
    kick_d  = kick_q;
    if (override) begin
      state_d = ST_FULL;
      kick_d  = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (temp_q >= thr_on) begin
            state_d = ST_KICK;
            kick_d  = '0;
          end
        end
        ST_KICK: begin
          // temperature is deliberately ignored until the kick has elapsed
          if (tick) begin
            if (kick_q == KICK_LAST) begin
              kick_d  = '0;
              state_d = (temp_q >= thr_full) ? ST_FULL : ST_RUN;
            end else begin
              kick_d = kick_q + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (temp_q >= thr_full) begin
            state_d = ST_FULL;
          end else if (temp_q < off_thr) begin
            state_d = ST_OFF;
          end
        end
        ST_FULL: begin
          if (temp_q < run_thr) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Duty latch at counter wrap and PWM level from the current state
  always_comb begin
    duty_d = wrap ? duty_run : duty_q;
    case (state_q)
      ST_OFF:  pwm_d = 1'b0;
      // all-ones duty means a true 100%, not 255/256
      ST_RUN:  pwm_d = (&duty_q) | (pwm_cnt < duty_q);
      default: pwm_d = 1'b1;
    endcase
  end

  // Channel state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      kick_q  <= '0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kick_q  <= kick_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
    end
  end

  assign fan_pwm   = pwm_q;
  assign fan_state = state_q;

`ifdef FAN_TACH_EN
  // tsync[0..1] synchronise the tach pin, tsync[2] holds the previous synced level
  logic [2:0] tsync_q, tsync_d;
  logic [2:0] edge_cnt_q, edge_cnt_d;
  logic       stall_q, stall_d;
  logic       tach_rise;

  assign tach_rise = tsync_q[1] & ~tsync_q[2];

  // Count tach edges per window and judge the stall at window end
  always_comb begin
    tsync_d    = {tsync_q[1:0], fan_tach};
    edge_cnt_d = edge_cnt_q;
    stall_d    = stall_q;
    if (state_q == ST_OFF || state_q == ST_KICK) begin
      edge_cnt_d = '0;
      stall_d    = 1'b0;
    end else if (wrap) begin
      stall_d    = (edge_cnt_q < 3'd2);
      edge_cnt_d = '0;
    end else if (tach_rise && edge_cnt_q != 3'd7) begin
      edge_cnt_d = edge_cnt_q + 3'd1;
    end
  end

  // Tach registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tsync_q    <= '0;
      edge_cnt_q <= '0;
      stall_q    <= 1'b0;
    end else begin
      tsync_q    <= tsync_d;
      edge_cnt_q <= edge_cnt_d;
      stall_q    <= stall_d;
    end
  end

  assign fan_stall = stall_q;
`endif

endmodule

// File: rtl/fan_ctrl_multi.sv
// Multi-channel fan PWM controller. Shares the prescaler, PWM counter,
// captured temperature and sticky over-temperature flag across NCH channels.
// Optional tach stall detection is enabled by defining FAN_TACH_EN.
module fan_ctrl_multi
  import fan_ctrl_pkg::*;
#(
  parameter int            NCH        = 1,
  parameter int            TW         = 12,
  parameter int            PWM_BITS   = 8,
  parameter int            PRESCALE   = 64,
  parameter int            KICK_TICKS = 1024,
  parameter logic [TW-1:0] OT_LIMIT   = TW'(3000)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    temp_valid,
  input  logic [TW-1:0]           temp,
  input  logic [NCH*TW-1:0]       thr_on,
  input  logic [NCH*TW-1:0]       thr_full,
  input  logic [TW-1:0]           hyst,
  input  logic [NCH*PWM_BITS-1:0] duty_run,
  input  logic                    force_full,
`ifdef FAN_TACH_EN
  input  logic [NCH-1:0]          fan_tach,
  output logic [NCH-1:0]          fan_stall,
`endif
  output logic [NCH-1:0]          fan_pwm,
  output logic [2*NCH-1:0]        fan_state,
  output logic                    overtemp
);

  localparam int             PSW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

  logic [PSW-1:0]      presc_q, presc_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [TW-1:0]       temp_q, temp_d;
  logic                ot_q, ot_d;
  logic                tick, wrap, override;
  logic [TW-1:0]       ot_clr_thr;

  assign tick       = (presc_q == PS_LAST);
  assign wrap       = tick & (&cnt_q);
  assign override   = force_full | ot_q;
  assign ot_clr_thr = TW'(sat_sub(32'(OT_LIMIT), 32'(hyst)));

  // Shared timebase, temperature capture and sticky over-temperature flag
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    cnt_d   = tick ? cnt_q + 1'b1 : cnt_q;
    temp_d  = temp_valid ? temp : temp_q;
    ot_d    = ot_q ? (temp_q >= ot_clr_thr) : (temp_q >= OT_LIMIT);
  end

  // Shared registers
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      temp_q  <= '0;
      ot_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      temp_q  <= temp_d;
      ot_q    <= ot_d;
    end
  end

  assign overtemp = ot_q;

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_ch
      fan_ch_fsm #(
        .TW        (TW),
        .PWM_BITS  (PWM_BITS),
        .KICK_TICKS(KICK_TICKS)
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .wrap     (wrap),
        .pwm_cnt  (cnt_q),
        .temp_q   (temp_q),
        .thr_on   (thr_on[g*TW +: TW]),
        .thr_full (thr_full[g*TW +: TW]),
        .hyst     (hyst),
        .duty_run (duty_run[g*PWM_BITS +: PWM_BITS]),
        .override (override),
        .fan_pwm  (fan_pwm[g]),
`ifdef FAN_TACH_EN
        .fan_tach (fan_tach[g]),
        .fan_stall(fan_stall[g]),
`endif
        .fan_state(fan_state[2*g +: 2])
      );
    end
  endgenerate

endmodule

// File: tb/tb_fan_ctrl_multi.sv
// Bench for fan_ctrl_multi: directed scenarios followed by randomized
// stimulus, compared every cycle against a behavioural model.
module tb_fan_ctrl_multi;

  localparam int NCH        = 2;
  localparam int TW         = 12;
  localparam int PWM_BITS   = 8;
  localparam int PRESCALE   = 4;
  localparam int KICK_TICKS = 16;
  localparam int OT_LIMIT   = 3000;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    temp_valid;
  logic [TW-1:0]           temp;
  logic [NCH*TW-1:0]       thr_on;
  logic [NCH*TW-1:0]       thr_full;
  logic [TW-1:0]           hyst;
  logic [NCH*PWM_BITS-1:0] duty_run;
  logic                    force_full;
  logic [NCH-1:0]          fan_pwm;
  logic [2*NCH-1:0]        fan_state;
  logic                    overtemp;
`ifdef FAN_TACH_EN
  logic [NCH-1:0]          fan_tach;
  logic [NCH-1:0]          fan_stall;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // behavioural model state
  int m_cyc;
  int m_st   [NCH];
  int m_kick [NCH];
  int m_duty [NCH];
  bit m_pwm  [NCH];
  bit m_ot;
  int m_tq;

  always #5 clk = ~clk;

  fan_ctrl_multi #(
    .NCH       (NCH),
    .TW        (TW),
    .PWM_BITS  (PWM_BITS),
    .PRESCALE  (PRESCALE),
    .KICK_TICKS(KICK_TICKS),
    .OT_LIMIT  (12'd3000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .temp_valid(temp_valid),
    .temp      (temp),
    .thr_on    (thr_on),
    .thr_full  (thr_full),
    .hyst      (hyst),
    .duty_run  (duty_run),
    .force_full(force_full),
`ifdef FAN_TACH_EN
    .fan_tach  (fan_tach),
    .fan_stall (fan_stall),
`endif
    .fan_pwm   (fan_pwm),
    .fan_state (fan_state),
    .overtemp  (overtemp)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int a, input int b);
    return (a > b) ? a - b : 0;
  endfunction

  // One clock of the reference behaviour, evaluated from the inputs seen at the edge
  task automatic model_step();
    int  cnt, on, full, off_t, run_t, tq_old;
    bit  tick, wrap, ov;
    if (rst) begin
      m_cyc = 0;
      m_ot  = 0;
      m_tq  = 0;
      for (int c = 0; c < NCH; c++) begin
        m_st[c] = 0; m_kick[c] = 0; m_duty[c] = 0; m_pwm[c] = 0;
      end
      return;
    end
    tick   = (m_cyc % PRESCALE) == PRESCALE - 1;
    cnt    = (m_cyc / PRESCALE) % (1 << PWM_BITS);
    wrap   = tick && (cnt == (1 << PWM_BITS) - 1);
    ov     = force_full || m_ot;
    tq_old = m_tq;
    for (int c = 0; c < NCH; c++) begin
      on    = int'(thr_on[c*TW +: TW]);
      full  = int'(thr_full[c*TW +: TW]);
      off_t = sat(on, int'(hyst));
      run_t = sat(full, int'(hyst));
      if (m_st[c] == 0)      m_pwm[c] = 0;
      else if (m_st[c] == 2) m_pwm[c] = (m_duty[c] == 255) || (cnt < m_duty[c]);
      else                   m_pwm[c] = 1;
      if (ov) begin
        m_st[c] = 3; m_kick[c] = 0;
      end else begin
        case (m_st[c])
          0: if (tq_old >= on) begin m_st[c] = 1; m_kick[c] = 0; end
          1: if (tick) begin
               m_kick[c]++;
               if (m_kick[c] == KICK_TICKS) begin
                 m_kick[c] = 0;
                 m_st[c]   = (tq_old >= full) ? 3 : 2;
               end
             end
          2: if (tq_old >= full) m_st[c] = 3;
             else if (tq_old < off_t) m_st[c] = 0;
          default: if (tq_old < run_t) m_st[c] = 2;
        endcase
      end
      if (wrap) m_duty[c] = int'(duty_run[c*PWM_BITS +: PWM_BITS]);
    end
    if (m_ot) m_ot = !(tq_old < sat(OT_LIMIT, int'(hyst)));
    else      m_ot = tq_old >= OT_LIMIT;
    if (temp_valid) m_tq = int'(temp);
    m_cyc++;
  endtask

  // Advance one clock and compare every output against the model
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("state%0d", c), 32'(fan_state[2*c +: 2]), 32'(m_st[c]));
      chk($sformatf("pwm%0d", c), 32'(fan_pwm[c]), 32'(m_pwm[c]));
    end
    chk("overtemp", 32'(overtemp), 32'(m_ot));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_temp(input int t);
    temp       = 12'(t);
    temp_valid = 1'b1;
    step();
    temp_valid = 1'b0;
  endtask

  initial begin
    int hi;
    int r;
    rst        = 1'b1;
    temp       = 12'd4000;
    temp_valid = 1'b1;
    thr_on     = {12'd1500, 12'd1000};
    thr_full   = {12'd2500, 12'd2000};
    hyst       = 12'd50;
    duty_run   = {8'd128, 8'd64};
    force_full = 1'b0;
`ifdef FAN_TACH_EN
    fan_tach   = '0;
`endif

    // reset with a hot reading pending
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_pwm", 32'(fan_pwm), 32'd0);
      chk("rst_state", 32'(fan_state), 32'd0);
      chk("rst_ot", 32'(overtemp), 32'd0);
`ifdef FAN_TACH_EN
      chk("rst_stall", 32'(fan_stall), 32'd0);
`endif
    end
    rst        = 1'b0;
    temp_valid = 1'b0;
    steps(4);

    // spin-up through KICK into RUN
    set_temp(1200);
    step();
    chk("spin_kick", 32'(fan_state[1:0]), 32'd1);
    hi = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (fan_pwm[0]) hi++;
    end
    chk("kick_high", 32'(hi), 32'd60);
    steps(10);
    chk("spin_run", 32'(fan_state[1:0]), 32'd2);
    chk("ch1_off", 32'(fan_state[3:2]), 32'd0);
    steps(1100);
    hi = 0;
    for (int i = 0; i < 1024; i++) begin
      step();
      if (fan_pwm[0]) hi++;
    end
    chk("run_duty64", 32'(hi), 32'd256);

    // hysteresis on the way down
    set_temp(960);
    steps(2);
    chk("hyst_hold", 32'(fan_state[1:0]), 32'd2);
    set_temp(949);
    steps(2);
    chk("hyst_off", 32'(fan_state[1:0]), 32'd0);
    chk("hyst_pwm", 32'(fan_pwm[0]), 32'd0);

    // FULL entry and return
    set_temp(2000);
    steps(80);
    chk("full_ch0", 32'(fan_state[1:0]), 32'd3);
    chk("run_ch1", 32'(fan_state[3:2]), 32'd2);
    chk("full_pwm", 32'(fan_pwm[0]), 32'd1);
    set_temp(1960);
    steps(3);
    chk("full_hold", 32'(fan_state[1:0]), 32'd3);
    set_temp(1949);
    steps(3);
    chk("full_to_run", 32'(fan_state[1:0]), 32'd2);

    // override from KICK, then sticky over-temperature
    set_temp(900);
    steps(2);
    set_temp(1200);
    step();
    chk("ov_kick", 32'(fan_state[1:0]), 32'd1);
    force_full = 1'b1;
    step();
    chk("ov_full", 32'(fan_state), 32'hF);
    step();
    chk("ov_pwm", 32'(fan_pwm), 32'h3);
    set_temp(3000);
    steps(2);
    chk("ot_set", 32'(overtemp), 32'd1);
    force_full = 1'b0;
    set_temp(2960);
    steps(3);
    chk("ot_hold", 32'(overtemp), 32'd1);
    chk("ot_full", 32'(fan_state), 32'hF);
    set_temp(2949);
    step();
    chk("ot_clear", 32'(overtemp), 32'd0);
    steps(3);

`ifdef FAN_TACH_EN
    // stall detection: silent tach, then ~5 edges per window
    set_temp(1200);
    steps(2100);
    chk("stall_set", 32'(fan_stall[0]), 32'd1);
    for (int i = 0; i < 2200; i++) begin
      fan_tach[0] = ((i / 100) % 2) == 1;
      step();
    end
    chk("stall_clr", 32'(fan_stall[0]), 32'd0);
    fan_tach = '0;
`endif

    // randomized operation with occasional reconfiguration, override and reset
    for (int it = 0; it < 3000; it++) begin
      if (it % 200 == 0) begin
        for (int c = 0; c < NCH; c++) begin
          thr_on[c*TW +: TW]   = 12'($urandom_range(300, 2500));
          thr_full[c*TW +: TW] = 12'($urandom_range(300, 3000));
        end
        hyst = 12'($urandom_range(0, 700));
      end
      if (it % 50 == 0) begin
        for (int c = 0; c < NCH; c++) begin
          r = int'($urandom_range(0, 3));
          duty_run[c*PWM_BITS +: PWM_BITS] = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom);
        end
      end
      temp_valid = ($urandom_range(0, 7) == 0);
      r = int'($urandom_range(0, 3));
      case (r)
        0: hi = int'($urandom_range(0, 4095));
        1: hi = int'(thr_on[TW-1:0]) + int'($urandom_range(0, 120)) - 60;
        2: hi = int'(thr_full[TW-1:0]) + int'($urandom_range(0, 120)) - 60;
        default: hi = OT_LIMIT + int'($urandom_range(0, 160)) - 80;
      endcase
      if (hi < 0) hi = 0;
      if (hi > 4095) hi = 4095;
      temp       = 12'(hi);
      force_full = ($urandom_range(0, 49) == 0);
      rst        = ($urandom_range(0, 499) == 0);
      step();
    end
    rst        = 1'b0;
    temp_valid = 1'b0;
    force_full = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
